hiscore_ctrl: RTL and testbench
===============================

# hiscore_ctrl

Sequencer for the core's high-score RAM port (`hs_address`, `hs_data_in`, `hs_data_out`, `hs_write`, `hs_access`). It sits between the ioctl loader and the centipede core. A hiscore-index download restores the table; a hiscore-index upload saves it. For each session the block pauses the core, waits for it to settle, claims the port, serialises byte accesses with `ioctl_wait` back-pressure, then releases the port and unpauses the core.

## Interface
Parameters:
- `HS_ADDR_W`, 7: hiscore address width.
- `HS_SIZE`, 128: number of valid table bytes. Must be ≤ 2^HS_ADDR_W.
- `HS_INDEX`, 8'h04: ioctl index that selects the hiscore table.
- `SETTLE`, 4: cycles of pause before `hs_access` rises. Must be ≥ 1.
- `READ_LAT`, 1: cycles from `hs_address` presented to `hs_data_out` valid. Must be ≥ 1.

Ports (one clock `clk_12`; reset `reset` is asynchronous and active-high):
- `clk_12` in 1: 12 MHz system clock.
- `reset` in 1: async active-high reset.
- `ioctl_download` in 1: framework download session active.
- `ioctl_upload` in 1: framework upload session active.
- `ioctl_index` in 8: session target index.
- `ioctl_write` in 1: one-cycle download byte strobe.
- `ioctl_rd` in 1: one-cycle upload byte request.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: download data.
- `ioctl_din` out 8: upload data.
- `ioctl_wait` out 1: stall to framework.
- `pause_o` out 1: pause request to core.
- `hs_access` out 1: port claimed.
- `hs_address` out HS_ADDR_W: port address.
- `hs_data_in` out 8: write data to core.
- `hs_data_out` in 8: read data from core.
- `hs_write` out 1: one-cycle write strobe.

## Operation
- States: IDLE, SETTLE, READY, WRITE, READ, RELEASE.
- **IDLE → SETTLE.** Triggered by a rising edge of `ioctl_download` or `ioctl_upload` while `ioctl_index == HS_INDEX`.
  - Latch the session type.
  - If both edges occur in the same cycle, download wins.
  - Other indices are ignored entirely.
- **SETTLE.** `pause_o` = 1. A counter loads SETTLE−1 and counts down to 0, then the FSM moves to READY.
- **READY.**
  - `pause_o` = 1 and `hs_access` = 1.
  - A download `ioctl_write` with `ioctl_addr < HS_SIZE` → WRITE.
  - An upload `ioctl_rd` → READ.
- **WRITE.**
  - `hs_address` = `ioctl_addr[HS_ADDR_W-1:0]`, `hs_data_in` = `ioctl_dout`, both as latched at the strobe.
  - `hs_write` = 1 for exactly one cycle, then return to READY.
- **READ.**
  - Present the latched address and wait READ_LAT cycles.
  - Capture `hs_data_out` into `ioctl_din`, then return to READY.
  - If the address is ≥ HS_SIZE, skip the port access and load `ioctl_din` = 8'hFF.
- **Early strobes.** A strobe arriving in SETTLE is held in a one-entry holding register with `ioctl_wait` = 1. It is issued on entry to READY.
  - Only one strobe is outstanding. The framework honours `ioctl_wait`, so a second strobe while waiting is a protocol violation and is dropped.
- **Out-of-range writes.** A download write with address ≥ HS_SIZE is discarded: no `hs_write` and no wait.
- **Session end.** The latched session signal falls. Any pending op completes first, then the FSM goes to RELEASE.
  - RELEASE: `hs_access` = 0 and `pause_o` still 1 for one cycle, then IDLE with `pause_o` = 0.
- **Signal hygiene.** Outside WRITE, `hs_write` is 0. `hs_address` and `hs_data_in` hold their last values.
- **Reset.**
  - All outputs go to 0 immediately: `ioctl_din` = 0, `ioctl_wait` = 0, `pause_o` = 0, `hs_access` = 0, `hs_write` = 0, `hs_address` = 0, `hs_data_in` = 0.
  - FSM goes to IDLE and the holding register is cleared.
  - Mid-session reset abandons the session. A new rising edge is required to restart.

## Timing
- **Start.** Trigger edge seen in cycle 0 → `pause_o` = 1 from cycle 1; `hs_access` = 1 from cycle 1+SETTLE.
- **Download write in READY.** Strobe in cycle N → `hs_write` = 1 in cycle N+1 only. `ioctl_wait` stays 0. Back-to-back strobes are allowed every 2 cycles.
- **Download write in SETTLE.** `ioctl_wait` = 1 from cycle N+1 until the cycle `hs_write` is asserted, which is the first READY cycle plus 1.
- **Upload read in READY.** `ioctl_rd` in cycle N:
  - `ioctl_wait` = 1 and `hs_address` valid from N+1.
  - `hs_data_out` is sampled at the end of cycle N+READ_LAT.
  - `ioctl_din` is valid and `ioctl_wait` = 0 from cycle N+1+READ_LAT.
- **End.** Session signal falls in cycle M with nothing pending → `hs_access` = 0 at M+1, `pause_o` = 0 at M+2.

## Structure
- A shared package `hiscore_pkg` holds the state enum (`HS_IDLE`, `HS_SETTLE`, `HS_READY`, `HS_WRITE`, `HS_READ`, `HS_RELEASE`) and the default `HS_INDEX` constant.
- One sub-module is natural: `hs_edge_det`, a registered rising-edge detector used for `ioctl_download` and `ioctl_upload`.
- Everything else lives in `hiscore_ctrl`: the FSM, the SETTLE/READ_LAT down-counter, and the holding register.

## Test plan
- **Download restore.** Index 4; download rises; writes to addrs 0, 1, 127 with data 8'hA5, 8'h5A, 8'h3C, issued after `hs_access` is high.
  - Expect three single-cycle `hs_write` pulses with matching address/data.
  - Expect `ioctl_wait` never asserted.
  - Expect `pause_o` to fall 2 cycles after download falls.
- **Early write.** Write to addr 2, data 8'h11, in cycle 1.
  - Expect `ioctl_wait` high until `hs_write` at cycle SETTLE+2, with address 2 and data 8'h11.
- **Upload save.** Model core RAM[5] = 8'hC3; `ioctl_rd` addr 5 in READY at cycle N.
  - Expect `ioctl_wait` high during N+1..N+1+READ_LAT−1, then `ioctl_din` = 8'hC3 with `ioctl_wait` low at N+1+READ_LAT.
  - Addr 200 → `ioctl_din` = 8'hFF and no port read.
- **Wrong index.** Index 0 download with writes.
  - Expect `pause_o`, `hs_access` and `hs_write` all to stay 0.
- **Simultaneous start.** Download and upload rise together at index 4.
  - Expect a download session: writes are accepted and `ioctl_rd` is ignored.
- **Reset mid-session.** Reset in READY while a read is pending.
  - Expect every output to be 0 immediately.
  - Expect no `hs_access` after reset deassertion until a new rising edge.

Source files
------------

// File: rtl/hiscore_pkg.sv
// Shared types and constants for the high-score RAM sequencer.
package hiscore_pkg;

    typedef enum logic [2:0] {
        HS_IDLE,
        HS_SETTLE,
        HS_READY,
        HS_WRITE,
        HS_READ,
        HS_RELEASE
    } hs_state_t;

    localparam logic [7:0]  HS_INDEX_DEFAULT = 8'h04;
    localparam int unsigned IOCTL_ADDR_W     = 25;
    localparam int unsigned BYTE_W           = 8;

    // Width of a down-counter that must hold max(a, b) - 1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/hs_edge_det.sv
// Rising-edge detector with a registered history bit.
module hs_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise_c
);

    logic prev;

    // History resets high so a level still asserted across reset is not taken as a new edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= d;
        end
    end

    assign rise_c = d & ~prev;

endmodule

// File: rtl/hiscore_ctrl.sv
// Sequences ioctl hiscore download/upload sessions onto the core's high-score RAM port.
module hiscore_ctrl
    import hiscore_pkg::*;
#(
    parameter int unsigned HS_ADDR_W = 7,
    parameter int unsigned HS_SIZE   = 128,
    parameter logic [7:0]  HS_INDEX  = HS_INDEX_DEFAULT,
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic                 clk_12,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic                 ioctl_upload,
    input  logic [7:0]           ioctl_index,
    input  logic                 ioctl_write,
    input  logic                 ioctl_rd,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic [7:0]           ioctl_din,
    output logic                 ioctl_wait,
    output logic                 pause_o,
    output logic                 hs_access,
    output logic [HS_ADDR_W-1:0] hs_address,
    output logic [7:0]           hs_data_in,
    input  logic [7:0]           hs_data_out,
    output logic                 hs_write
);

    localparam int unsigned CNT_W = cnt_width(SETTLE, READ_LAT);

    hs_state_t state, state_d;

    logic [CNT_W-1:0]     cnt, cnt_d;
    logic                 sess_dl, sess_dl_d;
    logic                 hold_vld, hold_vld_d;
    logic                 hold_rd, hold_rd_d;
    logic                 hold_oor, hold_oor_d;
    logic [HS_ADDR_W-1:0] hold_addr, hold_addr_d;
    logic [7:0]           hold_data, hold_data_d;
    logic                 op_oor, op_oor_d;

    logic [7:0]           din_d;
    logic                 wait_d;
    logic                 pause_d;
    logic                 access_d;
    logic [HS_ADDR_W-1:0] address_d;
    logic [7:0]           data_in_d;
    logic                 write_d;

    logic                 dl_rise_c;
    logic                 ul_rise_c;
    logic                 idx_hit_c;
    logic                 in_range_c;
    logic                 sess_lvl_c;
    logic                 wr_req_c;
    logic                 rd_req_c;

    logic                 iss_c;
    logic                 iss_rd_c;
    logic                 iss_oor_c;
    logic [HS_ADDR_W-1:0] iss_addr_c;
    logic [7:0]           iss_data_c;

    hs_edge_det u_dl_edge (
        .clk    (clk_12),
        .rst    (reset),
        .d      (ioctl_download),
        .rise_c (dl_rise_c)
    );

    hs_edge_det u_ul_edge (
        .clk    (clk_12),
        .rst    (reset),
        .d      (ioctl_upload),
        .rise_c (ul_rise_c)
    );

    // Request decode: writes only in download sessions, reads only in upload sessions.
    assign idx_hit_c  = (ioctl_index == HS_INDEX);
    assign in_range_c = (ioctl_addr < IOCTL_ADDR_W'(HS_SIZE));
    assign sess_lvl_c = sess_dl ? ioctl_download : ioctl_upload;
    assign wr_req_c   = sess_dl & ioctl_write & in_range_c;
    assign rd_req_c   = ~sess_dl & ioctl_rd;

    // A held early strobe takes priority over a fresh one.
    assign iss_c      = hold_vld | wr_req_c | rd_req_c;
    assign iss_rd_c   = hold_vld ? hold_rd   : rd_req_c;
    assign iss_oor_c  = hold_vld ? hold_oor  : ~in_range_c;
    assign iss_addr_c = hold_vld ? hold_addr : ioctl_addr[HS_ADDR_W-1:0];
    assign iss_data_c = hold_vld ? hold_data : ioctl_dout;

    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            state      <= HS_IDLE;
            cnt        <= '0;
            sess_dl    <= 1'b0;
            hold_vld   <= 1'b0;
            hold_rd    <= 1'b0;
            hold_oor   <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
            op_oor     <= 1'b0;
            ioctl_din  <= '0;
            ioctl_wait <= 1'b0;
            pause_o    <= 1'b0;
            hs_access  <= 1'b0;
            hs_address <= '0;
            hs_data_in <= '0;
            hs_write   <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sess_dl    <= sess_dl_d;
            hold_vld   <= hold_vld_d;
            hold_rd    <= hold_rd_d;
            hold_oor   <= hold_oor_d;
            hold_addr  <= hold_addr_d;
            hold_data  <= hold_data_d;
            op_oor     <= op_oor_d;
            ioctl_din  <= din_d;
            ioctl_wait <= wait_d;
            pause_o    <= pause_d;
            hs_access  <= access_d;
            hs_address <= address_d;
            hs_data_in <= data_in_d;
            hs_write   <= write_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        sess_dl_d   = sess_dl;
        hold_vld_d  = hold_vld;
        hold_rd_d   = hold_rd;
        hold_oor_d  = hold_oor;
        hold_addr_d = hold_addr;
        hold_data_d = hold_data;
        op_oor_d    = op_oor;
        din_d       = ioctl_din;
        address_d   = hs_address;
        data_in_d   = hs_data_in;
        write_d     = 1'b0;

        unique case (state)
            HS_IDLE: begin
                if (idx_hit_c && (dl_rise_c || ul_rise_c)) begin
                    sess_dl_d = dl_rise_c;
                    cnt_d     = CNT_W'(SETTLE - 1);
                    state_d   = HS_SETTLE;
                end
            end
            HS_SETTLE: begin
                if ((wr_req_c || rd_req_c) && !hold_vld) begin
                    hold_vld_d  = 1'b1;
                    hold_rd_d   = rd_req_c;
                    hold_oor_d  = ~in_range_c;
                    hold_addr_d = ioctl_addr[HS_ADDR_W-1:0];
                    hold_data_d = ioctl_dout;
                end
                if (cnt == '0) begin
                    state_d = HS_READY;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            HS_READY: begin
                if (iss_c) begin
                    hold_vld_d = 1'b0;
                    if (iss_rd_c) begin
                        state_d  = HS_READ;
                        cnt_d    = CNT_W'(READ_LAT - 1);
                        op_oor_d = iss_oor_c;
                        if (!iss_oor_c) begin
                            address_d = iss_addr_c;
                        end
                    end else begin
                        state_d   = HS_WRITE;
                        address_d = iss_addr_c;
                        data_in_d = iss_data_c;
                        write_d   = 1'b1;
                    end
                end else if (!sess_lvl_c) begin
                    state_d = HS_RELEASE;
                end
            end
            HS_WRITE: begin
                state_d = HS_READY;
            end
            HS_READ: begin
                if (cnt == '0) begin
                    din_d   = op_oor ? 8'hFF : hs_data_out;
                    state_d = HS_READY;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            HS_RELEASE: begin
                state_d = HS_IDLE;
            end
            default: begin
                state_d = HS_IDLE;
            end
        endcase

        // Registered outputs follow the state being entered.
        pause_d  = (state_d != HS_IDLE);
        access_d = (state_d == HS_READY) || (state_d == HS_WRITE) || (state_d == HS_READ);
        wait_d   = hold_vld_d || (state_d == HS_READ);
    end

endmodule

// File: tb/tb_hiscore_ctrl.sv
// Scoreboarded bench for hiscore_ctrl: directed session checks plus randomized restore/save rounds.
module tb_hiscore_ctrl;

    localparam int unsigned SETTLE   = 4;
    localparam int unsigned READ_LAT = 1;
    localparam int unsigned HS_SIZE  = 128;

    logic        clk_12 = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_write;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        pause_o;
    logic        hs_access;
    logic [6:0]  hs_address;
    logic [7:0]  hs_data_in;
    logic [7:0]  hs_data_out;
    logic        hs_write;

    always #5 clk_12 = ~clk_12;

    hiscore_ctrl #(
        .HS_ADDR_W (7),
        .HS_SIZE   (HS_SIZE),
        .HS_INDEX  (8'h04),
        .SETTLE    (SETTLE),
        .READ_LAT  (READ_LAT)
    ) dut (
        .clk_12         (clk_12),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_upload   (ioctl_upload),
        .ioctl_index    (ioctl_index),
        .ioctl_write    (ioctl_write),
        .ioctl_rd       (ioctl_rd),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_din      (ioctl_din),
        .ioctl_wait     (ioctl_wait),
        .pause_o        (pause_o),
        .hs_access      (hs_access),
        .hs_address     (hs_address),
        .hs_data_in     (hs_data_in),
        .hs_data_out    (hs_data_out),
        .hs_write       (hs_write)
    );

    typedef struct packed {
        logic       is_rd;
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_mem [128];
    logic [7:0] core_ram  [128];
    logic       ram_loaded = 1'b0;
    logic       wait_q     = 1'b0;
    int         tests = 0;
    int         fails = 0;

    assign hs_data_out = core_ram[hs_address];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_12);
        #1;
    endtask

    // Monitor: models the core RAM and pops the scoreboard on each write strobe or read completion.
    always @(negedge clk_12) begin
        exp_t e;
        if (!ram_loaded) begin
            for (int i = 0; i < 128; i++) core_ram[i] = model_mem[i];
            ram_loaded = 1'b1;
        end
        if (reset) begin
            wait_q <= 1'b0;
        end else begin
            if (hs_write) begin
                core_ram[hs_address] = hs_data_in;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %0h data %0h", hs_address, hs_data_in);
                end else begin
                    e = sb.pop_front();
                    check("sb_kind_write", 32'(e.is_rd), 32'(0));
                    check("wr_addr", 32'(hs_address), 32'(e.addr));
                    check("wr_data", 32'(hs_data_in), 32'(e.data));
                end
            end else if (wait_q && !ioctl_wait) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_read_done: din %0h", ioctl_din);
                end else begin
                    e = sb.pop_front();
                    check("sb_kind_read", 32'(e.is_rd), 32'(1));
                    check("rd_data", 32'(ioctl_din), 32'(e.data));
                end
            end
            wait_q <= ioctl_wait;
        end
    end

    task automatic start_session(input logic dl, input logic ul, input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = dl;
        ioctl_upload   = ul;
        tick();
    endtask

    task automatic wait_access();
        for (int i = 0; i < 40 && !hs_access; i++) tick();
        check("access_up", 32'(hs_access), 32'(1));
    endtask

    task automatic end_session();
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b0;
        tick();
        check("end_access_low", 32'(hs_access), 32'(0));
        check("end_pause_held", 32'(pause_o), 32'(1));
        tick();
        check("end_pause_low", 32'(pause_o), 32'(0));
    endtask

    // accept: the current session is a hiscore download, so in-range writes must land.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic accept);
        logic hit;
        hit = accept && (a < 8'(HS_SIZE));
        if (hit) begin
            sb.push_back('{is_rd: 1'b0, addr: a[6:0], data: d});
            model_mem[a[6:0]] = d;
        end
        ioctl_write = 1'b1;
        ioctl_addr  = 25'(a);
        ioctl_dout  = d;
        tick();
        ioctl_write = 1'b0;
        check("wr_strobe", 32'(hs_write), 32'(hit));
        check("wr_no_wait", 32'(ioctl_wait), 32'(0));
        tick();
        check("wr_one_cycle", 32'(hs_write), 32'(0));
    endtask

    // accept: the current session is a hiscore upload.
    task automatic do_read(input logic [7:0] a, input logic accept);
        logic [6:0] addr_before;
        logic [7:0] din_before;
        logic [7:0] expv;
        addr_before = hs_address;
        din_before  = ioctl_din;
        expv = (a < 8'(HS_SIZE)) ? model_mem[a[6:0]] : 8'hFF;
        if (accept) sb.push_back('{is_rd: 1'b1, addr: a[6:0], data: expv});
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'(a);
        tick();
        ioctl_rd = 1'b0;
        if (accept) begin
            if (a < 8'(HS_SIZE)) check("rd_addr", 32'(hs_address), 32'(a[6:0]));
            for (int i = 0; i < int'(READ_LAT); i++) begin
                check("rd_wait_high", 32'(ioctl_wait), 32'(1));
                tick();
            end
            check("rd_wait_low", 32'(ioctl_wait), 32'(0));
            check("rd_din", 32'(ioctl_din), 32'(expv));
            if (a >= 8'(HS_SIZE)) check("rd_oor_no_port", 32'(hs_address), 32'(addr_before));
        end else begin
            check("rd_ignored_wait", 32'(ioctl_wait), 32'(0));
            tick();
            check("rd_ignored_din", 32'(ioctl_din), 32'(din_before));
        end
    endtask

    function automatic logic [31:0] out_bits();
        return 32'({ioctl_din, ioctl_wait, pause_o, hs_access, hs_write, hs_address, hs_data_in});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) model_mem[i] = 8'($urandom);
        model_mem[5]   = 8'hC3;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_write    = 1'b0;
        ioctl_rd       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        repeat (3) tick();
        check("reset_outputs", out_bits(), 32'(0));
        reset = 1'b0;
        tick();

        // Download restore with start timing.
        start_session(1'b1, 1'b0, 8'h04);
        check("start_pause", 32'(pause_o), 32'(1));
        check("start_access_low", 32'(hs_access), 32'(0));
        repeat (SETTLE - 1) tick();
        check("settle_access_low", 32'(hs_access), 32'(0));
        tick();
        check("settle_access_high", 32'(hs_access), 32'(1));
        do_write(8'd0,   8'hA5, 1'b1);
        do_write(8'd1,   8'h5A, 1'b1);
        do_write(8'd127, 8'h3C, 1'b1);
        do_write(8'd200, 8'h77, 1'b1);
        end_session();

        // Early write in the settle window.
        start_session(1'b1, 1'b0, 8'h04);
        sb.push_back('{is_rd: 1'b0, addr: 7'd2, data: 8'h11});
        model_mem[2] = 8'h11;
        ioctl_write = 1'b1;
        ioctl_addr  = 25'd2;
        ioctl_dout  = 8'h11;
        tick();
        ioctl_write = 1'b0;
        for (int c = 2; c <= int'(SETTLE) + 1; c++) begin
            check("early_wait_high", 32'(ioctl_wait), 32'(1));
            check("early_no_write", 32'(hs_write), 32'(0));
            tick();
        end
        check("early_write", 32'(hs_write), 32'(1));
        check("early_wait_low", 32'(ioctl_wait), 32'(0));
        check("early_addr", 32'(hs_address), 32'(2));
        tick();
        end_session();

        // Upload save, including an out-of-range address.
        start_session(1'b0, 1'b1, 8'h04);
        wait_access();
        do_read(8'd5, 1'b1);
        do_read(8'd200, 1'b1);
        do_read(8'd2, 1'b1);
        end_session();

        // Wrong index is ignored.
        start_session(1'b1, 1'b0, 8'h00);
        do_write(8'd3, 8'h99, 1'b0);
        repeat (SETTLE + 2) tick();
        do_write(8'd4, 8'h98, 1'b0);
        check("wrong_idx_pause", 32'(pause_o), 32'(0));
        check("wrong_idx_access", 32'(hs_access), 32'(0));
        ioctl_download = 1'b0;
        tick();

        // Simultaneous start: download wins.
        start_session(1'b1, 1'b1, 8'h04);
        wait_access();
        do_read(8'd5, 1'b0);
        do_write(8'd9, 8'h42, 1'b1);
        end_session();

        // Reset mid-session with a read pending.
        start_session(1'b0, 1'b1, 8'h04);
        wait_access();
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'd5;
        tick();
        ioctl_rd = 1'b0;
        check("pre_reset_wait", 32'(ioctl_wait), 32'(1));
        #2 reset = 1'b1;
        #1 check("reset_async_outputs", out_bits(), 32'(0));
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (hs_access || pause_o) begin
                check("no_restart_after_reset", 32'({pause_o, hs_access}), 32'(0));
                break;
            end
        end
        check("post_reset_idle", 32'({pause_o, hs_access}), 32'(0));
        ioctl_upload = 1'b0;
        tick();
        start_session(1'b0, 1'b1, 8'h04);
        check("restart_pause", 32'(pause_o), 32'(1));
        wait_access();
        do_read(8'd9, 1'b1);
        end_session();

        // Randomized restore/save rounds.
        for (int r = 0; r < 4; r++) begin
            start_session(1'b1, 1'b0, 8'h04);
            wait_access();
            for (int k = 0; k < 8; k++) begin
                do_write(8'($urandom_range(0, 159)), 8'($urandom), 1'b1);
                repeat ($urandom_range(0, 2)) tick();
            end
            end_session();
            start_session(1'b0, 1'b1, 8'h04);
            wait_access();
            for (int k = 0; k < 6; k++) begin
                do_read(8'($urandom_range(0, 255)), 1'b1);
                repeat ($urandom_range(0, 2)) tick();
            end
            end_session();
        end

        repeat (3) tick();
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
